// File: rtl/kdtree_pkg.sv
// Shared types and constants for the k-d tree node walker.
package kdtree_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int QIDX_WIDTH = 9;
  localparam int NUM_LEAVES = 64;
  localparam int LEAF_ADDRW = $clog2(NUM_LEAVES);
  localparam int LEVELS     = LEAF_ADDRW;
  localparam int NODE_COUNT = NUM_LEAVES - 1;
  localparam int PATCH_W    = PATCH_SIZE * DATA_WIDTH;
  // Wide enough for the child index of the deepest internal node (2*62+2).
  localparam int NODE_IDXW  = LEAF_ADDRW + 1;

  // Node word layout on the Wishbone side.
  localparam int MEDIAN_LSB = 0;
  localparam int MEDIAN_MSB = 10;
  localparam int DIM_LSB    = 12;
  localparam int DIM_MSB    = 14;

  typedef struct packed {
    logic [2:0]            dim;
    logic [DATA_WIDTH-1:0] median;
  } node_t;

  typedef struct packed {
    logic                  valid;
    logic [NODE_IDXW-1:0]  node_idx;
    logic [QIDX_WIDTH-1:0] qidx;
    logic [PATCH_W-1:0]    patch;
  } stage_t;

  // Pack a stored node back into its bus word; unused bits read as zero.
  function automatic logic [31:0] node_to_word(input node_t n);
    logic [31:0] w;
    w = '0;
    w[MEDIAN_MSB:MEDIAN_LSB] = n.median;
    w[DIM_MSB:DIM_LSB]       = n.dim;
    return w;
  endfunction

endpackage

// File: rtl/kdtree_node_walker_if.sv
// Wishbone node-memory port, query stream and result stream of the walker.
interface kdtree_node_walker_if;
  import kdtree_pkg::*;

  logic                  wbs_debug;
  logic                  wbs_node_mem_web;
  logic [31:0]           wbs_node_mem_addr;
  logic [31:0]           wbs_node_mem_wdata;
  logic [31:0]           wbs_node_mem_rdata;

  logic                  in_valid;
  logic                  in_ready;
  logic [PATCH_W-1:0]    in_patch;
  logic [QIDX_WIDTH-1:0] in_qidx;

  logic                  out_valid;
  logic                  out_ready;
  logic [LEAF_ADDRW-1:0] out_leaf;
  logic [QIDX_WIDTH-1:0] out_qidx;
  logic [PATCH_W-1:0]    out_patch;

  logic                  busy;

  // Producer of queries / bus master / result consumer.
  modport master (
    output wbs_debug, wbs_node_mem_web, wbs_node_mem_addr, wbs_node_mem_wdata,
    output in_valid, in_patch, in_qidx, out_ready,
    input  wbs_node_mem_rdata, in_ready, out_valid, out_leaf, out_qidx,
    input  out_patch, busy
  );

  // The walker itself.
  modport slave (
    input  wbs_debug, wbs_node_mem_web, wbs_node_mem_addr, wbs_node_mem_wdata,
    input  in_valid, in_patch, in_qidx, out_ready,
    output wbs_node_mem_rdata, in_ready, out_valid, out_leaf, out_qidx,
    output out_patch, busy
  );
endinterface

// File: rtl/kdtree_walk_stage.sv
// One tree level: pick this level's node, compare the chosen patch element
// against its median and register the child index with the payload.
module kdtree_walk_stage
  import kdtree_pkg::*;
#(
  parameter int LEVEL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  node_t [(1<<LEVEL)-1:0]     level_nodes,
  input  stage_t                     in_pl,
  output stage_t                     out_pl
);

  localparam bit LAST = (LEVEL == LEVELS - 1);

  node_t                 node;
  logic [2:0]            dim;
  logic [DATA_WIDTH-1:0] elem;
  logic                  right;
  logic [NODE_IDXW-1:0]  child;
  logic [NODE_IDXW-1:0]  nxt_idx;

  // Node select from this level's slice (heap indices 2^L-1 .. 2^(L+1)-2).
  always_comb begin
    node = '0;
    for (int k = 0; k < (1 << LEVEL); k++)
      if (in_pl.node_idx == NODE_IDXW'((1 << LEVEL) - 1 + k))
        node = level_nodes[k];
  end

  // Split decision; out-of-range dims fall back to element 0, ties go right.
  always_comb begin
    dim     = (node.dim < 3'(PATCH_SIZE)) ? node.dim : 3'd0;
    elem    = in_pl.patch[dim*DATA_WIDTH +: DATA_WIDTH];
    right   = (elem >= node.median);
    child   = (in_pl.node_idx << 1) + NODE_IDXW'(1) + NODE_IDXW'(right);
    // Final level converts the heap index to a 0-based leaf number.
    nxt_idx = LAST ? child - NODE_IDXW'(NODE_COUNT) : child;
  end

  // Stage register; everything holds while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pl <= '0;
    end else if (en) begin
      out_pl.valid    <= in_pl.valid;
      out_pl.node_idx <= nxt_idx;
      out_pl.qidx     <= in_pl.qidx;
      out_pl.patch    <= in_pl.patch;
    end
  end

endmodule

// File: rtl/kdtree_node_walker.sv
// k-d tree walker: flop-based node store loaded over Wishbone and a
// LEVELS-deep pipeline that takes each query patch from root to leaf.
module kdtree_node_walker
  import kdtree_pkg::*;
(
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  kdtree_node_walker_if.slave  bus
);

  node_t [NODE_COUNT-1:0] nodes;
  logic [LEAF_ADDRW-1:0]  widx;
  logic                   idx_ok;
  logic                   en;
  logic                   busy_c;
  logic [31:0]            rdata;
  stage_t                 pl [LEVELS+1];

  assign widx   = bus.wbs_node_mem_addr[LEAF_ADDRW+1:2];
  assign idx_ok = (widx != LEAF_ADDRW'(NODE_COUNT));

  // Debug freezes traversal; a held result also stalls every stage.
  assign en           = ~bus.wbs_debug & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = en;

  // Node store write port; only the Wishbone side may write, and only in debug.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      nodes <= '0;
    end else if (bus.wbs_debug && bus.wbs_node_mem_web && idx_ok) begin
      nodes[widx] <= '{dim:    bus.wbs_node_mem_wdata[DIM_MSB:DIM_LSB],
                       median: bus.wbs_node_mem_wdata[MEDIAN_MSB:MEDIAN_LSB]};
    end
  end

  // Registered read port, available whether or not debug is set.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdata <= '0;
    end else if (!bus.wbs_node_mem_web) begin
      rdata <= idx_ok ? node_to_word(nodes[widx]) : 32'h0;
    end
  end

  assign bus.wbs_node_mem_rdata = rdata;

  // Every query enters at the root.
  assign pl[0] = '{valid:    bus.in_valid,
                   node_idx: '0,
                   qidx:     bus.in_qidx,
                   patch:    bus.in_patch};

  for (genvar l = 0; l < LEVELS; l++) begin : g_stage
    kdtree_walk_stage #(.LEVEL(l)) u_stage (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .en          (en),
      .level_nodes (nodes[(1<<l)-1 +: (1<<l)]),
      .in_pl       (pl[l]),
      .out_pl      (pl[l+1])
    );
  end

  // busy is derived only from stage registers, so it is registered with them.
  always_comb begin
    busy_c = 1'b0;
    for (int l = 1; l <= LEVELS; l++) busy_c = busy_c | pl[l].valid;
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = pl[LEVELS].valid;
  assign bus.out_leaf  = pl[LEVELS].node_idx[LEAF_ADDRW-1:0];
  assign bus.out_qidx  = pl[LEVELS].qidx;
  assign bus.out_patch = pl[LEVELS].patch;

  // Address/data bits outside the node word and the leaf-index carry bit.
  logic unused_bits;
  assign unused_bits = ^{bus.wbs_node_mem_addr[31:LEAF_ADDRW+2],
                         bus.wbs_node_mem_addr[1:0],
                         bus.wbs_node_mem_wdata[31:DIM_MSB+1],
                         bus.wbs_node_mem_wdata[DIM_LSB-1:MEDIAN_MSB+1],
                         pl[LEVELS].node_idx[LEAF_ADDRW]};

endmodule

// File: tb/tb_kdtree_node_walker.sv
// Directed bench for kdtree_node_walker with a small tree reference model.
module tb_kdtree_node_walker;
  import kdtree_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kdtree_node_walker_if bus();

  kdtree_node_walker dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tdim [NODE_COUNT];
  int tmed [NODE_COUNT];

  logic [5:0]  q_leaf  [$];
  logic [8:0]  q_qidx  [$];
  logic [54:0] q_patch [$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bus.wbs_node_mem_web   = 1'b1;
    bus.wbs_node_mem_addr  = a;
    bus.wbs_node_mem_wdata = d;
    tick();
    bus.wbs_node_mem_web   = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bus.wbs_node_mem_web  = 1'b0;
    bus.wbs_node_mem_addr = a;
    tick();
    d = bus.wbs_node_mem_rdata;
  endtask

  // Writes a node with junk in the ignored word bits.
  task automatic set_node(input int i, input int dim, input int med);
    logic [31:0] w;
    w = ($urandom() & 32'hFFFF_8800) | (32'(dim) << 12) | 32'(med);
    tdim[i] = dim;
    tmed[i] = med;
    wb_write({24'h0, 6'(i), 2'b00}, w);
  endtask

  function automatic logic [54:0] rand_patch();
    logic [54:0] p;
    for (int d = 0; d < 5; d++) p[d*11 +: 11] = 11'($urandom_range(0, 2047));
    return p;
  endfunction

  function automatic logic [5:0] model(input logic [54:0] p);
    int i;
    int d;
    logic [10:0] e;
    i = 0;
    for (int l = 0; l < 6; l++) begin
      d = (tdim[i] > 4) ? 0 : tdim[i];
      e = p[d*11 +: 11];
      if (int'(e) < tmed[i]) i = 2*i + 1;
      else                   i = 2*i + 2;
    end
    return 6'(i - 63);
  endfunction

  // One isolated query; checks latency and result fields.
  task automatic run_one(input string tag, input logic [54:0] p,
                         input logic [8:0] q, input logic [5:0] exp_leaf);
    int c;
    int t;
    bus.in_valid = 1'b1;
    bus.in_patch = p;
    bus.in_qidx  = q;
    c = cyc;
    tick();
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_latency"}, 64'(cyc - c), 64'd6);
    chk({tag, "_leaf"}, bus.out_leaf, exp_leaf);
    chk({tag, "_qidx"}, bus.out_qidx, q);
    chk({tag, "_patch"}, bus.out_patch, p);
    tick();
    chk({tag, "_drained"}, bus.out_valid, 1'b0);
  endtask

  task automatic pop_cmp(input string tag);
    chk({tag, "_have_expect"}, 64'(q_leaf.size() != 0), 64'd1);
    if (q_leaf.size() != 0) begin
      chk({tag, "_leaf"}, bus.out_leaf, q_leaf.pop_front());
      chk({tag, "_qidx"}, bus.out_qidx, q_qidx.pop_front());
      chk({tag, "_patch"}, bus.out_patch, q_patch.pop_front());
    end
  endtask

  // Streams n queries; rand_rdy toggles out_ready, else checks first latency.
  task automatic stream(input string tag, input int n, input bit rand_rdy, input int qbase);
    int sent = 0;
    int got = 0;
    int guard = 0;
    int first_acc = -1;
    bit first_out = 1'b1;
    bit held = 1'b0;
    bit acc;
    logic [5:0]  hl;
    logic [8:0]  hq;
    logic [54:0] hp;
    bus.in_valid  = 1'b1;
    bus.in_patch  = rand_patch();
    bus.in_qidx   = 9'(qbase);
    bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (held) begin
        chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_hold_leaf"}, bus.out_leaf, hl);
        chk({tag, "_hold_qidx"}, bus.out_qidx, hq);
        chk({tag, "_hold_patch"}, bus.out_patch, hp);
      end
      acc  = bus.in_valid & bus.in_ready;
      held = 1'b0;
      if (bus.out_valid) begin
        if (!rand_rdy && first_out) begin
          chk({tag, "_first_latency"}, 64'(cyc - first_acc), 64'd6);
          first_out = 1'b0;
        end
        if (bus.out_ready) begin
          pop_cmp(tag);
          got++;
        end else begin
          chk({tag, "_stall_in_ready"}, bus.in_ready, 1'b0);
          held = 1'b1;
          hl = bus.out_leaf;
          hq = bus.out_qidx;
          hp = bus.out_patch;
        end
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        q_leaf.push_back(model(bus.in_patch));
        q_qidx.push_back(bus.in_qidx);
        q_patch.push_back(bus.in_patch);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < n) begin
          bus.in_patch = rand_patch();
          bus.in_qidx  = 9'(qbase + sent);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.out_ready = 1'b1;
    chk({tag, "_count"}, 64'(got), 64'(n));
    chk({tag, "_leftover"}, 64'(q_leaf.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [54:0] p;
    int t;
    int got;

    bus.wbs_debug          = 1'b0;
    bus.wbs_node_mem_web   = 1'b0;
    bus.wbs_node_mem_addr  = '0;
    bus.wbs_node_mem_wdata = '0;
    bus.in_valid           = 1'b0;
    bus.in_patch           = '0;
    bus.in_qidx            = '0;
    bus.out_ready          = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.wbs_node_mem_rdata, 32'h0);
    chk("rst_out_leaf", bus.out_leaf, 6'h0);
    chk("rst_out_qidx", bus.out_qidx, 9'h0);
    chk("rst_out_patch", bus.out_patch, 55'h0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", bus.in_ready, 1'b1);
    wb_read(32'h0000_0010, d);
    chk("rst_node4", d, 32'h0);

    // Wishbone node access
    bus.wbs_debug = 1'b1;
    #1;
    chk("debug_in_ready", bus.in_ready, 1'b0);
    wb_write(32'h3004_0000, 32'h0000_3123);
    wb_read(32'h3004_0000, d);
    chk("wb_rw_node0", d, 32'h0000_3123);
    wb_write(32'h0000_00FC, 32'hFFFF_FFFF);
    wb_read(32'h0000_00FC, d);
    chk("wb_node63", d, 32'h0);
    wb_write(32'h0000_0004, 32'hFFFF_FFFF);
    wb_read(32'h0000_0004, d);
    chk("wb_mask_node1", d, 32'h0000_77FF);
    bus.wbs_debug = 1'b0;
    wb_write(32'h0000_0000, 32'h0000_1111);
    wb_read(32'h0000_0000, d);
    chk("wb_nodebug_write_ignored", d, 32'h0000_3123);

    // All nodes dim 0 median 1024
    bus.wbs_debug = 1'b1;
    for (int i = 0; i < NODE_COUNT; i++) set_node(i, 0, 1024);
    bus.wbs_debug = 1'b0;
    p = rand_patch(); p[10:0] = 11'd1023;
    run_one("dir_1023", p, 9'd1, 6'd0);
    p = rand_patch(); p[10:0] = 11'd2047;
    run_one("dir_2047", p, 9'd2, 6'd63);
    p = rand_patch(); p[10:0] = 11'd1024;
    run_one("dir_equal", p, 9'd3, 6'd63);

    // Out-of-range dim 6 behaves as dim 0
    bus.wbs_debug = 1'b1;
    for (int i = 0; i < NODE_COUNT; i++) set_node(i, 6, 1024);
    bus.wbs_debug = 1'b0;
    p = {44'hFFF_FFFF_FFFF, 11'd1023};
    run_one("dir_dim6", p, 9'd4, 6'd0);

    // Random tree, back-to-back then with random back-pressure
    bus.wbs_debug = 1'b1;
    for (int i = 0; i < NODE_COUNT; i++)
      set_node(i, $urandom_range(0, 7), $urandom_range(1, 2047));
    bus.wbs_debug = 1'b0;
    stream("b2b", 200, 1'b0, 16);
    stream("stall", 100, 1'b1, 300);

    // Freeze with three queries in flight
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_patch = rand_patch();
      bus.in_qidx  = 9'(400 + k);
      q_leaf.push_back(model(bus.in_patch));
      q_qidx.push_back(bus.in_qidx);
      q_patch.push_back(bus.in_patch);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.wbs_debug = 1'b1;
    #1;
    chk("frz_in_ready", bus.in_ready, 1'b0);
    chk("frz_busy", bus.busy, 1'b1);
    repeat (8) tick();
    chk("frz_out_valid", bus.out_valid, 1'b0);
    chk("frz_busy_held", bus.busy, 1'b1);
    bus.wbs_debug = 1'b0;
    got = 0;
    t = 0;
    while (got < 3 && t < 30) begin
      tick();
      t++;
      if (bus.out_valid) begin
        pop_cmp("frz");
        got++;
      end
    end
    chk("frz_count", 64'(got), 64'd3);

    // Reset mid-stream
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_patch = rand_patch();
      bus.in_qidx  = 9'(500 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("mid_busy_before", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b0;
    wb_read(32'h0000_0014, d);
    chk("mid_rst_node5", d, 32'h0);
    repeat (8) tick();
    chk("mid_rst_no_output", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kdtree_node_walker.md
# kdtree_node_walker

Stores the 63 internal k-d tree nodes (split dimension and median) loaded over Wishbone and walks each incoming query patch from root to leaf in a 6-stage pipeline. Emits the leaf index with the query index and patch. Upstream: the Wishbone controller's node-memory port and the query-patch stream from query memory. Downstream: the leaf-memory fetch / k-NN compare stage.

## Interface
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch
- QIDX_WIDTH, 9, query index width
- NUM_LEAVES, 64, leaves; must be a power of two
- LEAF_ADDRW, $clog2(NUM_LEAVES), leaf index width; also LEVELS

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_debug  in  1  1 = Wishbone owns node memory; traversal halted
- wbs_node_mem_web  in  1  1 = write, 0 = read
- wbs_node_mem_addr  in  32  byte address; node index = addr[7:2]
- wbs_node_mem_wdata  in  32  node word
- wbs_node_mem_rdata  out  32  registered read data
- in_valid / in_ready  in / out  1  query handshake
- in_patch  in  PATCH_SIZE*DATA_WIDTH  element d = bits [d*DATA_WIDTH +: DATA_WIDTH]
- in_qidx  in  QIDX_WIDTH  query index
- out_valid / out_ready  out / in  1  result handshake
- out_leaf  out  LEAF_ADDRW  leaf reached
- out_qidx, out_patch  out  as inputs  pass-through
- busy  out  1  any pipeline stage valid

## Operation
- Node word: [10:0] unsigned median, [14:12] split dim, other bits ignored on write and read back as 0.
- Heap order: root = 0; children of i are 2i+1 and 2i+2; nodes 0..62.
- Write: web=1 and wbs_debug=1 -> node[addr[7:2]] updated at the clock edge. Index 63 is ignored. Writes with wbs_debug=0 are ignored.
- Read: web=0 -> rdata = node word of addr[7:2] on the next cycle, regardless of wbs_debug. Index 63 reads 0.
- Decision at each stage: if patch[dim] < median, go to 2i+1, else go to 2i+2. Equality goes right. dim 5..7 is treated as dim 0.
- After LEVELS decisions, out_leaf = node_index - (NUM_LEAVES-1).
- Advance enable: en = ~wbs_debug & (~out_valid | out_ready). When en=0, all stages hold.
- in_ready = en.
- Node writes during traversal are legal but not required to be coherent. Software loads nodes only with wbs_debug=1, which drains nothing and freezes in-flight queries.

## Timing
- Reset: all node words 0, rdata 0, all stage valids 0, out_valid 0, out_leaf/out_qidx/out_patch 0, busy 0.
- in_ready = 1 after reset if wbs_debug=0.
- Latency: accept in cycle c (in_valid & in_ready) -> out_valid in cycle c+LEVELS with no stall. Each stall cycle adds one.
- Throughput: one query per cycle with out_ready held high.
- out_valid & ~out_ready: all outputs hold stable and in_ready=0 until the handshake.
- A write to node n at edge E is seen by a stage reading n in the cycle after E. Read of n in the same cycle as its write returns the old value.
- busy = OR of the stage valids, registered with them.
- Reset mid-flight: all queries in flight are dropped, and node contents are cleared.

## Structure
- Package kdtree_pkg holds:
  - node-word field localparams (MEDIAN_LSB/MSB, DIM_LSB/MSB)
  - NODE_COUNT = NUM_LEAVES-1
  - packed struct node_t {dim[2:0], median[10:0]}
  - stage payload struct {valid, node_idx, qidx, patch}
- Sub-module kdtree_walk_stage, instantiated LEVELS times. Each stage selects its node from the level's slice of the node array, selects patch[dim], compares, and registers the child index and payload under en.
- Node storage is flops (63 × 14 bits), one write port and LEVELS+1 read ports.

## Test plan
- Write 0x0000_3123 to address 0x3004_0000 with debug=1; read same address -> rdata 0x0000_3123 next cycle. Write to index 63, then read it -> 0.
- Load all nodes with dim 0, median 1024; drive patch elem0 = 1023 -> out_leaf 0; elem0 = 2047 -> out_leaf 63; elem0 = 1024 -> out_leaf 63 (equality goes right).
- Random tree plus 200 back-to-back queries with out_ready=1 -> results match reference model, in order, first out_valid exactly 6 cycles after first accept.
- Random out_ready toggling -> no loss or duplication, out_qidx sequence intact, outputs stable while stalled.
- Raise wbs_debug with 3 queries in flight -> in_ready=0, pipeline frozen, busy=1; drop debug -> the 3 results emerge unchanged.
- Assert wb_rst_i mid-stream -> out_valid and busy 0 immediately, node read returns 0 afterward.
